// File: rtl/nv_hs4_pkg.sv
// Shared definitions for the 4-phase REQ/ACK destination responder.
package nv_hs4_pkg;

    // Responder FSM encoding; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    // Legal depth of the request synchroniser.
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/nv_sync_bit_srst.sv
// N-stage single-bit synchroniser with synchronous active-high clear.
module nv_sync_bit_srst #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the chain; clear wipes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/nv_hs4_dst_responder.sv
// Destination end of a 4-phase level REQ/ACK crossing: synchronises the
// request, captures the bundled word, offers it on valid/ready and returns
// a registered acknowledge level.
module nv_hs4_dst_responder
    import nv_hs4_pkg::*;
#(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic          DST_CLK,
    input  logic          DST_RST,
    input  logic          SRC_REQ,
    input  logic [DW-1:0] SRC_DATA,
    output logic          DST_ACK,
    output logic          DST_VALID,
    output logic [DW-1:0] DST_DATA,
    input  logic          DST_READY,
    output logic          DST_BUSY,
    output logic          PROT_ERR,
    input  logic          ERR_CLR
);

    if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync_stages
        $error("nv_hs4_dst_responder: SYNC_STAGES must lie in 2..4");
    end

    logic          req_s;
    state_e        state_q, state_d;
    logic          valid_q, valid_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          err_set;
    logic [DW-1:0] data_q, data_d;

    nv_sync_bit_srst #(
        .STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk(DST_CLK),
        .rst(DST_RST),
        .d  (SRC_REQ),
        .q  (req_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        data_d  = data_q;
        err_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // SRC_DATA is stable here because the source holds it until ACK.
                if (req_s) begin
                    data_d  = SRC_DATA;
                    valid_d = 1'b1;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // Request withdrawn before the word was acknowledged.
                if (!req_s) begin
                    err_set = 1'b1;
                end
                if (DST_READY) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ack_d   = 1'b0;
                err_set = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        // Sticky error: a fresh violation outranks a same-cycle clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (ERR_CLR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State, handshake outputs, capture register and error flag.
    always_ff @(posedge DST_CLK) begin
        if (DST_RST) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign DST_ACK   = ack_q;
    assign DST_VALID = valid_q;
    assign DST_DATA  = data_q;
    assign DST_BUSY  = busy_q;
    assign PROT_ERR  = err_q;

endmodule

// File: tb/tb_nv_hs4_dst_responder.sv
// Self-checking bench for nv_hs4_dst_responder.
module tb_nv_hs4_dst_responder;

    localparam int DW = 32;
    localparam int SS = 3;

    logic          clk;
    logic          rst;
    logic          src_req;
    logic [DW-1:0] src_data;
    logic          dst_ack;
    logic          dst_valid;
    logic [DW-1:0] dst_data;
    logic          dst_ready;
    logic          dst_busy;
    logic          prot_err;
    logic          err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    nv_hs4_dst_responder #(
        .DW(DW),
        .SYNC_STAGES(SS)
    ) dut (
        .DST_CLK  (clk),
        .DST_RST  (rst),
        .SRC_REQ  (src_req),
        .SRC_DATA (src_data),
        .DST_ACK  (dst_ack),
        .DST_VALID(dst_valid),
        .DST_DATA (dst_data),
        .DST_READY(dst_ready),
        .DST_BUSY (dst_busy),
        .PROT_ERR (prot_err),
        .ERR_CLR  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_req   = 1'b0;
        src_data  = '0;
        dst_ready = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        src_req   = 1'b1;
        src_data  = 32'hA5A5_5A5A;
        dst_ready = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({dst_ack, dst_valid, dst_busy, prot_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ack/valid/busy/err=%b expected 0000", {dst_ack, dst_valid, dst_busy, prot_err});
        end
        n_checks++;
        if (dst_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", dst_data);
        end
        rst = 1'b0;
        // Chain was cleared, so VALID takes the full SS+1 cycles after release.
        for (int i = 1; i <= SS + 1; i++) begin
            tick();
            n_checks++;
            if (dst_valid !== (i == SS + 1)) begin
                n_fail++;
                $display("FAIL reset_release_latency: cycle %0d valid=%b expected %b", i, dst_valid, (i == SS + 1));
            end
        end
        n_checks++;
        if (dst_data !== 32'hA5A5_5A5A) begin
            n_fail++;
            $display("FAIL reset_release_data: got %h expected a5a55a5a", dst_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        src_data  = 32'hDEAD_BEEF;
        src_req   = 1'b1;
        dst_ready = 1'b1;
        for (int i = 1; i <= SS + 1; i++) begin
            tick();
            n_checks++;
            if (dst_valid !== (i == SS + 1)) begin
                n_fail++;
                $display("FAIL single_valid_latency: cycle %0d valid=%b expected %b", i, dst_valid, (i == SS + 1));
            end
        end
        n_checks++;
        if (dst_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_data: got %h expected deadbeef", dst_data);
        end
        tick();
        n_checks++;
        if ({dst_ack, dst_valid, dst_busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL single_ack_rise: ack/valid/busy=%b expected 101", {dst_ack, dst_valid, dst_busy});
        end
        src_req = 1'b0;
        for (int i = 1; i <= SS + 1; i++) begin
            tick();
            n_checks++;
            if (dst_ack !== (i != SS + 1)) begin
                n_fail++;
                $display("FAIL single_ack_fall: cycle %0d ack=%b expected %b", i, dst_ack, (i != SS + 1));
            end
        end
        n_checks++;
        if ({dst_busy, prot_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle: busy/err=%b expected 00", {dst_busy, prot_err});
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w;
        do_reset();
        w         = $urandom;
        src_data  = w;
        src_req   = 1'b1;
        dst_ready = 1'b0;
        repeat (SS + 1) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({dst_valid, dst_ack, dst_busy} !== 3'b101 || dst_data !== w) begin
                n_fail++;
                $display("FAIL backpressure_hold: cycle %0d valid/ack/busy=%b data=%h expected 101 data=%h",
                         i, {dst_valid, dst_ack, dst_busy}, dst_data, w);
            end
        end
        dst_ready = 1'b1;
        tick();
        n_checks++;
        if ({dst_valid, dst_ack} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_accept: valid/ack=%b expected 01", {dst_valid, dst_ack});
        end
        dst_ready = 1'b0;
        src_req   = 1'b0;
        repeat (SS + 1) tick();
        n_checks++;
        if ({dst_ack, dst_busy, prot_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL backpressure_idle: ack/busy/err=%b expected 000", {dst_ack, dst_busy, prot_err});
        end
    endtask

    // Source re-raises REQ whenever it sees ACK low; consumer applies random
    // backpressure. Delivered words must equal the sent sequence exactly.
    task automatic run_stream(input int n_words, input bit rand_data);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] got_q[$];
        logic [DW-1:0] w;
        int  phase     = 0;
        int  idx       = 0;
        int  delay     = 0;
        int  raise_cyc = 0;
        int  acc_cyc   = -10;
        int  cyc       = 0;
        bit  saw_valid = 1'b0;
        bit  done      = 1'b0;
        do_reset();
        while (!done && cyc < 3000) begin
            if (phase == 1 && !saw_valid && dst_valid) begin
                saw_valid = 1'b1;
                n_checks++;
                if (cyc - raise_cyc !== SS + 1) begin
                    n_fail++;
                    $display("FAIL stream_valid_latency: word %0d latency %0d expected %0d", idx, cyc - raise_cyc, SS + 1);
                end
            end
            if (cyc == acc_cyc + 1) begin
                n_checks++;
                if (dst_ack !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_ack_after_accept: word %0d ack=%b expected 1", idx, dst_ack);
                end
            end
            if (phase == 1 && dst_ack) begin
                src_req = 1'b0;
                phase   = 2;
            end else if (phase == 2 && !dst_ack) begin
                idx++;
                if (idx == n_words) done = 1'b1;
                else begin
                    phase = 0;
                    delay = rand_data ? int'($urandom_range(0, 3)) : 0;
                end
            end
            if (!done && phase == 0) begin
                if (delay > 0) delay--;
                else if (!dst_ack) begin
                    w         = rand_data ? DW'($urandom) : DW'(idx + 1);
                    src_data  = w;
                    src_req   = 1'b1;
                    exp_q.push_back(w);
                    raise_cyc = cyc;
                    saw_valid = 1'b0;
                    phase     = 1;
                end
            end
            dst_ready = 1'($urandom_range(0, 1));
            if (dst_valid && dst_ready) begin
                got_q.push_back(dst_data);
                acc_cyc = cyc;
            end
            tick();
            cyc++;
        end
        dst_ready = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL stream_timeout: finished %0d of %0d words", idx, n_words);
        end
        n_checks++;
        if (got_q.size() !== n_words) begin
            n_fail++;
            $display("FAIL stream_count: accepts %0d expected %0d", got_q.size(), n_words);
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL stream_word: index %0d got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if (prot_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_prot_err: got %b expected 0", prot_err);
        end
    endtask

    task automatic test_back_to_back();
        run_stream(8, 1'b0);
    endtask

    task automatic test_random_stream();
        run_stream(20, 1'b1);
    endtask

    task automatic test_violation();
        logic [DW-1:0] w;
        do_reset();
        w         = $urandom;
        src_data  = w;
        src_req   = 1'b1;
        dst_ready = 1'b0;
        repeat (SS + 1) tick();
        src_req = 1'b0;
        repeat (SS) tick();
        n_checks++;
        if (prot_err !== 1'b0) begin
            n_fail++;
            $display("FAIL violation_early: err=%b expected 0", prot_err);
        end
        tick();
        n_checks++;
        if ({prot_err, dst_valid} !== 2'b11 || dst_data !== w) begin
            n_fail++;
            $display("FAIL violation_flag: err/valid=%b data=%h expected 11 data=%h", {prot_err, dst_valid}, dst_data, w);
        end
        dst_ready = 1'b1;
        tick();
        n_checks++;
        if ({dst_ack, dst_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL violation_ack_rise: ack/valid=%b expected 10", {dst_ack, dst_valid});
        end
        dst_ready = 1'b0;
        tick();
        n_checks++;
        if ({dst_ack, dst_busy, prot_err} !== 3'b001) begin
            n_fail++;
            $display("FAIL violation_ack_pulse: ack/busy/err=%b expected 001", {dst_ack, dst_busy, prot_err});
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (prot_err !== 1'b0) begin
            n_fail++;
            $display("FAIL violation_clear: err=%b expected 0", prot_err);
        end
        // Set and clear in the same cycle: the set must win.
        src_req = 1'b1;
        repeat (SS + 1) tick();
        src_req = 1'b0;
        repeat (SS + 1) tick();
        err_clr = 1'b1;
        tick();
        n_checks++;
        if (prot_err !== 1'b1) begin
            n_fail++;
            $display("FAIL violation_set_wins: err=%b expected 1", prot_err);
        end
        dst_ready = 1'b1;
        tick();
        dst_ready = 1'b0;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if ({prot_err, dst_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL violation_clear_after: err/busy=%b expected 00", {prot_err, dst_busy});
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [DW-1:0] w;
        do_reset();
        src_data  = $urandom;
        src_req   = 1'b1;
        dst_ready = 1'b1;
        repeat (SS + 2) tick();
        n_checks++;
        if (dst_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL midack_setup: ack=%b expected 1", dst_ack);
        end
        rst     = 1'b1;
        src_req = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({dst_ack, dst_busy, dst_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midack_reset: ack/busy/valid=%b expected 000", {dst_ack, dst_busy, dst_valid});
        end
        tick();
        w        = $urandom;
        src_data = w;
        src_req  = 1'b1;
        repeat (SS + 1) tick();
        n_checks++;
        if (dst_valid !== 1'b1 || dst_data !== w) begin
            n_fail++;
            $display("FAIL midack_fresh_valid: valid=%b data=%h expected 1 data=%h", dst_valid, dst_data, w);
        end
        tick();
        n_checks++;
        if (dst_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL midack_fresh_ack: ack=%b expected 1", dst_ack);
        end
        src_req = 1'b0;
        repeat (SS + 1) tick();
        n_checks++;
        if ({dst_ack, dst_busy, prot_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL midack_fresh_idle: ack/busy/err=%b expected 000", {dst_ack, dst_busy, prot_err});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_random_stream();
        test_violation();
        test_reset_mid_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
